ct_fadd_pipe_sched: RTL and testbench
=====================================

Name: ct_fadd_pipe_sched

Overview:
Issue scheduler for the shared scalar FADD pipe (EX1–EX3).
- Arbitrates between two requesters: requester 0 is the scalar FP issue queue; requester 1 is the vector element sequencer.
- Tracks occupancy of the three stages with requester id and tag.
- Generates the ex1/ex2/ex3 pipedown strobes that the FADD datapath uses as register enables.
- Returns each completed op to writeback with its id and tag, under writeback backpressure.

Parameters:
TAG_W, 7, width of the per-op tag carried alongside each op (ROB/element id).

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  synchronous active-high reset
req0_vld  in  1  requester 0 op valid
req0_tag  in  TAG_W  requester 0 tag
req0_ready  out  1  requester 0 accepted this cycle
req1_vld  in  1  requester 1 op valid
req1_tag  in  TAG_W  requester 1 tag
req1_ready  out  1  requester 1 accepted this cycle
flush0  in  1  kill all in-flight requester-0 ops
wb_ready  in  1  writeback can take the EX3 result
ex1_src_sel  out  1  id of the op in EX1; datapath operand mux select
ex1_pipedown  out  1  EX1→EX2 register enable
ex2_pipedown  out  1  EX2→EX3 register enable
ex3_pipedown  out  1  EX3 result consumed (forward valid)
wb_vld  out  1  result valid to writeback
wb_id  out  1  requester id of the result
wb_tag  out  TAG_W  tag of the result
busy  out  1  any stage valid

Behaviour:
- State per stage Sk (k = 1..3): vld, id, tag. Round-robin pointer rr_last holds the id granted last.
- Reset (cpurst high at the clock edge):
  - all Sk.vld = 0, rr_last = 1, so requester 0 wins the first tie.
  - All outputs read 0: ready, pipedowns, wb_vld, busy, ex1_src_sel, wb_id, wb_tag.
  - Reset mid-operation discards in-flight ops; nothing is returned.
- Elastic advance (combinational, this cycle):
  - ex3_pipedown = S3.vld & wb_ready.
  - s3_free = !S3.vld | ex3_pipedown.
  - ex2_pipedown = S2.vld & s3_free.
  - s2_free = !S2.vld | ex2_pipedown.
  - ex1_pipedown = S1.vld & s2_free.
  - s1_free = !S1.vld | ex1_pipedown.
  - Bubbles collapse; a stalled stage holds its contents.
- Grant:
  - Only when s1_free.
  - One valid requester is granted alone.
  - With both valid, grant the id != rr_last.
  - reqN_ready = s1_free & grant==N.
  - req0_ready is forced 0 while flush0 is high.
  - rr_last updates only on an accepted handshake.
  - An accepted op is loaded into S1 at the edge: vld=1, id, tag.
- Latency: an accepted op at cycle T is in EX1 at T+1 and in EX3 at T+3. wb_vld is asserted at T+3 at the earliest. Full throughput is 1 op/cycle when wb_ready is held high.
- Outputs:
  - wb_vld = S3.vld & !(flush0 & S3.id==0).
  - wb_id and wb_tag come from S3.
  - ex1_src_sel = S1.id.
  - busy = |Sk.vld.
- Backpressure: while wb_ready=0 with the pipe full, all pipedowns and readies are 0 and the contents are stable.
- Flush:
  - At the edge of a cycle with flush0=1, every stage whose next-state id==0 has vld cleared. This covers entries that moved this cycle.
  - Requester-1 entries are unaffected and keep advancing normally in the flush cycle.
  - A requester-0 result in S3 during flush0 is not returned: wb_vld=0, and the entry is dropped even if wb_ready=0.
- Simultaneous cases:
  - S3 draining and a grant in the same cycle are both allowed.
  - flush0 together with a req1 grant: the req1 op is accepted.

Optional Feature:
FADD_SCHED_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, requester 0 always wins ties. rr_last is not implemented and req1 is granted only when req0_vld=0 or flush0=1.

Decomposition:
- Shared package: requester id constants (FADD_REQ_SCALAR=0, FADD_REQ_VEC=1) and a stage-entry struct {vld, id, tag}.
- One natural sub-module, ct_fadd_sched_arb: two-way arbiter with a round-robin pointer, compile-switched by the macro.

Test Plan:
- Reset, then req0 with tag 5 accepted at T; wb_ready=1 → wb_vld=1, wb_id=0, wb_tag=5 at T+3; busy=0 at T+4.
- req0 and req1 both valid continuously with RR_EN, wb_ready=1 → grants alternate 0,1,0,1; wb_vld high every cycle from T+3.
- Pipe full, wb_ready=0 for 4 cycles → all pipedowns and readies 0, wb_tag stable; release → one result per cycle resumes.
- S1=req0 tag 1, S2=req1 tag 2, S3=req0 tag 3, flush0 pulsed with wb_ready=0 → wb_vld=0 that cycle; only tag 2 is later returned.
- Without RR_EN, both requesters valid for 3 cycles → req1_ready stays 0; drop req0_vld → req1 is granted the next free cycle.
- cpurst asserted with 3 ops in flight → next cycle busy=0, wb_vld=0, and no stale results afterwards.

Source files
------------

// File: rtl/ct_fadd_pipe_sched_pkg.sv
// ----------------------------------------------------------------------------
// ct_fadd_pipe_sched_pkg
//   Shared definitions for the FADD pipe issue scheduler.
//   - requester id constants (scalar FP issue queue / vector element sequencer)
//   - per-stage occupancy entry {vld, id, tag}
//   - helper that kills a scalar entry when flush0 is asserted
//   Optional build macro used by this block: FADD_SCHED_RR_EN
// ----------------------------------------------------------------------------
package ct_fadd_pipe_sched_pkg;

  localparam int   FADD_TAG_W      = 7;

  localparam logic FADD_REQ_SCALAR = 1'b0;
  localparam logic FADD_REQ_VEC    = 1'b1;

  typedef struct packed {
    logic                  vld;
    logic                  id;
    logic [FADD_TAG_W-1:0] tag;
  } fadd_stage_t;

  localparam fadd_stage_t FADD_STAGE_EMPTY = '0;

  // Drops an entry that belongs to the scalar requester while flush0 is high.
  // Applied to next-state values so entries moving this cycle are covered too.
  function automatic fadd_stage_t fadd_kill_scalar(input fadd_stage_t entry,
                                                   input logic        flush);
    fadd_stage_t res;
    res = entry;
    if (flush && entry.vld && (entry.id == FADD_REQ_SCALAR)) begin
      res = FADD_STAGE_EMPTY;
    end
    return res;
  endfunction

endpackage

// File: rtl/ct_fadd_pipe_sched_if.sv
// ----------------------------------------------------------------------------
// ct_fadd_pipe_sched_if
//   Requester and writeback handshake bundle of the FADD pipe scheduler.
//   Ports (by modport):
//     master : drives req0/req1 valid+tag and wb_ready; sees readies and wb_*
//     slave  : the scheduler; sees requests and wb_ready; drives readies, wb_*
// ----------------------------------------------------------------------------
interface ct_fadd_pipe_sched_if #(
  parameter int TAG_W = 7
);

  logic             req0_vld;
  logic [TAG_W-1:0] req0_tag;
  logic             req0_ready;

  logic             req1_vld;
  logic [TAG_W-1:0] req1_tag;
  logic             req1_ready;

  logic             wb_ready;
  logic             wb_vld;
  logic             wb_id;
  logic [TAG_W-1:0] wb_tag;

  modport master (
    output req0_vld, req0_tag,
    output req1_vld, req1_tag,
    output wb_ready,
    input  req0_ready, req1_ready,
    input  wb_vld, wb_id, wb_tag
  );

  modport slave (
    input  req0_vld, req0_tag,
    input  req1_vld, req1_tag,
    input  wb_ready,
    output req0_ready, req1_ready,
    output wb_vld, wb_id, wb_tag
  );

endinterface

// File: rtl/ct_fadd_pipe_sched_arb.sv
// ----------------------------------------------------------------------------
// ct_fadd_sched_arb
//   Two-way issue arbiter for the FADD pipe.
//   Build macro FADD_SCHED_RR_EN:
//     defined   - round robin; a tie goes to the requester not granted last
//     undefined - fixed priority; requester 0 wins ties, no pointer state
//   Ports:
//     forever_cpuclk  clock (round-robin build only)
//     cpurst          synchronous active-high reset; also blocks grants
//     req0_vld        scalar requester valid
//     req1_vld        vector requester valid
//     flush0          scalar flush; the scalar requester cannot be accepted
//     s1_free         EX1 can take a new op this cycle
//     gnt0 / gnt1     accepted handshake for requester 0 / 1 (drives readies)
// ----------------------------------------------------------------------------
module ct_fadd_sched_arb
  import ct_fadd_pipe_sched_pkg::*;
(
`ifdef FADD_SCHED_RR_EN
  input  logic forever_cpuclk,
`endif
  input  logic cpurst,
  input  logic req0_vld,
  input  logic req1_vld,
  input  logic flush0,
  input  logic s1_free,
  output logic gnt0,
  output logic gnt1
);

  logic r0_eff;
  logic r1_eff;

  // A flushed scalar request is masked before arbitration so that a
  // concurrent vector request is accepted instead of stalling the slot.
  assign r0_eff = req0_vld & ~flush0 & ~cpurst;
  assign r1_eff = req1_vld & ~cpurst;

`ifdef FADD_SCHED_RR_EN
  logic rr_last;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rr_last <= FADD_REQ_VEC;
    end else if (gnt0) begin
      rr_last <= FADD_REQ_SCALAR;
    end else if (gnt1) begin
      rr_last <= FADD_REQ_VEC;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (s1_free) begin
      if (r0_eff && r1_eff) begin
        gnt0 = (rr_last == FADD_REQ_VEC);
        gnt1 = (rr_last == FADD_REQ_SCALAR);
      end else begin
        gnt0 = r0_eff;
        gnt1 = r1_eff;
      end
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (s1_free) begin
      gnt0 = r0_eff;
      gnt1 = r1_eff & ~r0_eff;
    end
  end
`endif

endmodule

// File: rtl/ct_fadd_pipe_sched.sv
// ----------------------------------------------------------------------------
// ct_fadd_pipe_sched
//   Issue scheduler for the shared scalar FADD pipe (EX1..EX3). Tracks stage
//   occupancy with requester id and tag, produces the stage pipedown enables
//   for the datapath and returns completed ops to writeback.
//   Build macro FADD_SCHED_RR_EN selects round-robin arbitration (default:
//   fixed priority, scalar requester first).
//   Ports:
//     forever_cpuclk  clock
//     cpurst          synchronous active-high reset, discards in-flight ops
//     sched_if        slave side: req0/req1 valid/tag/ready, wb_ready,
//                     wb_vld/wb_id/wb_tag
//     flush0          kill all in-flight scalar ops
//     ex1_src_sel     id of the op in EX1 (operand mux select)
//     ex1_pipedown    EX1->EX2 register enable
//     ex2_pipedown    EX2->EX3 register enable
//     ex3_pipedown    EX3 result consumed
//     busy            any stage valid
// ----------------------------------------------------------------------------
module ct_fadd_pipe_sched
  import ct_fadd_pipe_sched_pkg::*;
#(
  parameter int TAG_W = FADD_TAG_W
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  ct_fadd_pipe_sched_if.slave     sched_if,
  input  logic                    flush0,
  output logic                    ex1_src_sel,
  output logic                    ex1_pipedown,
  output logic                    ex2_pipedown,
  output logic                    ex3_pipedown,
  output logic                    busy
);

  fadd_stage_t      s1_q, s2_q, s3_q;
  fadd_stage_t      s1_nxt, s2_nxt, s3_nxt;
  logic             s1_free, s2_free, s3_free;
  logic             gnt0, gnt1;
  logic [TAG_W-1:0] acc_tag;

  // Elastic advance, resolved from the writeback end backwards.
  assign ex3_pipedown = s3_q.vld & sched_if.wb_ready;
  assign s3_free      = ~s3_q.vld | ex3_pipedown;
  assign ex2_pipedown = s2_q.vld & s3_free;
  assign s2_free      = ~s2_q.vld | ex2_pipedown;
  assign ex1_pipedown = s1_q.vld & s2_free;
  assign s1_free      = ~s1_q.vld | ex1_pipedown;

  ct_fadd_sched_arb u_arb (
`ifdef FADD_SCHED_RR_EN
    .forever_cpuclk (forever_cpuclk),
`endif
    .cpurst         (cpurst),
    .req0_vld       (sched_if.req0_vld),
    .req1_vld       (sched_if.req1_vld),
    .flush0         (flush0),
    .s1_free        (s1_free),
    .gnt0           (gnt0),
    .gnt1           (gnt1)
  );

  assign sched_if.req0_ready = gnt0;
  assign sched_if.req1_ready = gnt1;
  assign acc_tag             = gnt1 ? sched_if.req1_tag : sched_if.req0_tag;

  always_comb begin
    s3_nxt = s3_q;
    if (ex2_pipedown) begin
      s3_nxt = s2_q;
    end else if (s3_free) begin
      s3_nxt = FADD_STAGE_EMPTY;
    end

    s2_nxt = s2_q;
    if (ex1_pipedown) begin
      s2_nxt = s1_q;
    end else if (s2_free) begin
      s2_nxt = FADD_STAGE_EMPTY;
    end

    s1_nxt = s1_q;
    if (gnt0 | gnt1) begin
      s1_nxt.vld = 1'b1;
      s1_nxt.id  = gnt1 ? FADD_REQ_VEC : FADD_REQ_SCALAR;
      s1_nxt.tag = acc_tag;
    end else if (s1_free) begin
      s1_nxt = FADD_STAGE_EMPTY;
    end

    // A scalar entry stuck in EX3 under backpressure is dropped here as well.
    s1_nxt = fadd_kill_scalar(s1_nxt, flush0);
    s2_nxt = fadd_kill_scalar(s2_nxt, flush0);
    s3_nxt = fadd_kill_scalar(s3_nxt, flush0);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_q <= FADD_STAGE_EMPTY;
      s2_q <= FADD_STAGE_EMPTY;
      s3_q <= FADD_STAGE_EMPTY;
    end else begin
      s1_q <= s1_nxt;
      s2_q <= s2_nxt;
      s3_q <= s3_nxt;
    end
  end

  assign sched_if.wb_vld = s3_q.vld & ~(flush0 & (s3_q.id == FADD_REQ_SCALAR));
  assign sched_if.wb_id  = s3_q.id;
  assign sched_if.wb_tag = s3_q.tag;
  assign ex1_src_sel     = s1_q.id;
  assign busy            = s1_q.vld | s2_q.vld | s3_q.vld;

endmodule

// File: tb/tb_ct_fadd_pipe_sched.sv
module tb_ct_fadd_pipe_sched;
  import ct_fadd_pipe_sched_pkg::*;

  localparam int TAG_W = FADD_TAG_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic cpurst;
  logic flush0;
  logic ex1_src_sel, ex1_pipedown, ex2_pipedown, ex3_pipedown, busy;

  ct_fadd_pipe_sched_if #(.TAG_W(TAG_W)) sif ();

  ct_fadd_pipe_sched #(.TAG_W(TAG_W)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .sched_if       (sif),
    .flush0         (flush0),
    .ex1_src_sel    (ex1_src_sel),
    .ex1_pipedown   (ex1_pipedown),
    .ex2_pipedown   (ex2_pipedown),
    .ex3_pipedown   (ex3_pipedown),
    .busy           (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference pipe: three slots, slot 3 is next to writeback.
  logic             m_vld [1:3];
  logic             m_id  [1:3];
  logic [TAG_W-1:0] m_tag [1:3];
  logic             m_rr;

  // Tags actually returned by the DUT (valid & ready at writeback).
  logic [TAG_W-1:0] ret_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic rst, input logic v0, input logic [TAG_W-1:0] t0,
                      input logic v1, input logic [TAG_W-1:0] t1,
                      input logic fl, input logic wr);
    logic             fr   [1:4];
    logic             e_pd [1:3];
    logic             n_vld [1:3];
    logic             n_id  [1:3];
    logic [TAG_W-1:0] n_tag [1:3];
    logic r0, r1, g0, g1, e_wbv;

    @(negedge clk);
    cpurst       = rst;
    sif.req0_vld = v0;
    sif.req0_tag = t0;
    sif.req1_vld = v1;
    sif.req1_tag = t1;
    flush0       = fl;
    sif.wb_ready = wr;
    #1;

    // A slot is free if empty or its occupant leaves; beyond slot 3 is writeback.
    fr[4] = wr;
    for (int k = 3; k >= 1; k--) begin
      e_pd[k] = m_vld[k] && fr[k+1];
      fr[k]   = !m_vld[k] || e_pd[k];
    end

    r0 = v0 && !fl && !rst;
    r1 = v1 && !rst;
    g0 = 1'b0;
    g1 = 1'b0;
    if (fr[1]) begin
`ifdef FADD_SCHED_RR_EN
      if (r0 && r1) begin
        g0 = (m_rr == 1'b1);
        g1 = (m_rr == 1'b0);
      end
`else
      if (r0 && r1) g0 = 1'b1;
`endif
      else begin
        g0 = r0;
        g1 = r1;
      end
    end

    e_wbv = m_vld[3] && !(fl && m_id[3] == 1'b0);

    chk("req0_ready", sif.req0_ready, g0);
    chk("req1_ready", sif.req1_ready, g1);
    chk("ex1_pipedown", ex1_pipedown, e_pd[1]);
    chk("ex2_pipedown", ex2_pipedown, e_pd[2]);
    chk("ex3_pipedown", ex3_pipedown, e_pd[3]);
    chk("busy", busy, m_vld[1] || m_vld[2] || m_vld[3]);
    chk("wb_vld", sif.wb_vld, e_wbv);
    if (e_wbv) begin
      chk("wb_id", sif.wb_id, m_id[3]);
      chk("wb_tag", sif.wb_tag, m_tag[3]);
    end
    if (m_vld[1]) chk("ex1_src_sel", ex1_src_sel, m_id[1]);

    if (sif.wb_vld && wr) ret_q.push_back(sif.wb_tag);

    // Advance the reference pipe.
    for (int k = 1; k <= 3; k++) begin
      n_vld[k] = m_vld[k];
      n_id[k]  = m_id[k];
      n_tag[k] = m_tag[k];
    end
    for (int k = 3; k >= 2; k--) begin
      if (e_pd[k-1]) begin
        n_vld[k] = 1'b1;
        n_id[k]  = m_id[k-1];
        n_tag[k] = m_tag[k-1];
      end else if (fr[k]) begin
        n_vld[k] = 1'b0;
      end
    end
    if (g0 || g1) begin
      n_vld[1] = 1'b1;
      n_id[1]  = g1;
      n_tag[1] = g1 ? t1 : t0;
    end else if (fr[1]) begin
      n_vld[1] = 1'b0;
    end
    if (fl) begin
      for (int k = 1; k <= 3; k++) if (n_id[k] == 1'b0) n_vld[k] = 1'b0;
    end
    if (g0) m_rr = 1'b0;
    if (g1) m_rr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      m_vld[k] = n_vld[k];
      m_id[k]  = n_id[k];
      m_tag[k] = n_tag[k];
    end
    if (rst) begin
      for (int k = 1; k <= 3; k++) begin
        m_vld[k] = 1'b0;
        m_id[k]  = 1'b0;
        m_tag[k] = '0;
      end
      m_rr = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic wr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, wr);
  endtask

  initial begin
    cpurst       = 1'b1;
    flush0       = 1'b0;
    sif.req0_vld = 1'b0;
    sif.req0_tag = '0;
    sif.req1_vld = 1'b0;
    sif.req1_tag = '0;
    sif.wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      m_vld[k] = 1'b0;
      m_id[k]  = 1'b0;
      m_tag[k] = '0;
    end
    m_rr = 1'b1;

    // Reset state.
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_vld", sif.wb_vld, 1'b0);
    chk("rst_wb_tag", sif.wb_tag, 0);
    chk("rst_src_sel", ex1_src_sel, 1'b0);

    // Single scalar op, tag 5.
    ret_q.delete();
    step(1'b0, 1'b1, 7'd5, 1'b0, '0, 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("single_ret_cnt", ret_q.size(), 1);
    if (ret_q.size() > 0) chk("single_ret_tag", ret_q[0], 5);

    // Both requesters valid continuously, then a stall of 4 cycles.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 7'(16 + i), 1'b1, 7'(48 + i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'h11, 1'b1, 7'h22, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(64 + i), 1'b0, '0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Fixed-priority/round-robin contention then req0 drops out.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'(80 + i), 1'b1, 7'h30, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 7'h31, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Flush with S1=req0/1, S2=req1/2, S3=req0/3 under backpressure.
    ret_q.delete();
    step(1'b0, 1'b1, 7'd3, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 7'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'd1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(5, 1'b1);
    chk("flush_ret_cnt", ret_q.size(), 1);
    if (ret_q.size() > 0) chk("flush_ret_tag", ret_q[0], 2);

    // Reset with three ops in flight.
    ret_q.delete();
    step(1'b0, 1'b1, 7'd9, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 7'd10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'd11, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_wb_vld", sif.wb_vld, 1'b0);
    idle(4, 1'b1);
    chk("midrst_no_stale", ret_q.size(), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0, 7'($urandom),
           $urandom_range(0, 3) != 0, 7'($urandom),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
    end
    idle(5, 1'b1);
    chk("final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
